// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory access, writeback.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module core_ctrl #(
  parameter int unsigned XLEN              = 32,
  parameter bit          RESET_STATE_FETCH = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            zero_i,
  input  logic            mem_ack_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_addr_sel_o,
  output logic            ir_we_o,
  output logic            mdr_we_o,
  output logic [11:0]     alu_op_o,
  output logic            opr2_sel_o,
  output logic            rf_we_o,
  output logic            wb_sel_o,
  output logic            pc_we_o,
  output logic [1:0]      pc_sel_o,
  output logic            retire_o,
  output logic            illegal_o
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMem, StWriteback, StTrap
  } state_e;

  state_e state_q, state_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, f3_forced;
  logic        legal, opr2_imm;
  logic [11:0] alu_op_dec;
  logic        unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign rd           = instr_i[11:7];
  assign unused_instr = ^{instr_i[XLEN-1:31], instr_i[29:15]};

  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign f3_forced = (opcode == OpLui) || (opcode == OpAuipc) || is_jal || is_jalr;
  assign opr2_imm  = (opcode == OpImm) || is_load || is_store || (opcode == OpLui) ||
                     (opcode == OpAuipc);

  // b11 selects SUB/SRA for register ops, b10 selects SRAI for immediate shifts.
  assign alu_op_dec = {(opcode == OpR) & instr_i[30],
                       (opcode == OpImm) & (funct3 == 3'b101) & instr_i[30],
                       f3_forced ? 3'b000 : funct3,
                       opcode};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpR, OpImm, OpJal, OpJalr, OpLui, OpAuipc: legal = 1'b1;
      OpLoad:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OpStore:  legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OpBranch: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (RESET_STATE_FETCH) state_q <= StFetch;
      else                   state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are gated by rst_ni so a pending request drops the moment reset asserts.
  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    mdr_we_o       = 1'b0;
    alu_op_o       = 12'h000;
    opr2_sel_o     = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_o       = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = 2'd0;
    retire_o       = 1'b0;
    illegal_o      = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) state_d = StFetch;
        end
        StFetch: begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            ir_we_o = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          alu_op_o   = alu_op_dec;
          opr2_sel_o = opr2_imm;
          if (legal) begin
            state_d = StExecute;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = StTrap;
`else
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = StFetch;
`endif
          end
        end
        StExecute: begin
          alu_op_o   = alu_op_dec;
          opr2_sel_o = opr2_imm;
          if (is_load || is_store) begin
            state_d = StMem;
          end else if (is_branch) begin
            pc_we_o  = 1'b1;
            pc_sel_o = zero_i ? 2'd1 : 2'd0;
            retire_o = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
        StMem: begin
          alu_op_o       = alu_op_dec;
          opr2_sel_o     = opr2_imm;
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = is_store;
          if (mem_ack_i) begin
            if (is_store) begin
              pc_we_o  = 1'b1;
              retire_o = 1'b1;
              state_d  = StFetch;
            end else begin
              mdr_we_o = 1'b1;
              state_d  = StWriteback;
            end
          end
        end
        StWriteback: begin
          alu_op_o   = alu_op_dec;
          opr2_sel_o = opr2_imm;
          rf_we_o    = (rd != 5'd0);
          wb_sel_o   = is_load;
          pc_we_o    = 1'b1;
          pc_sel_o   = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
          retire_o   = 1'b1;
          state_d    = StFetch;
        end
        StTrap: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_o = 1'b1;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed vector table, hand-written corner sequences and
// randomized instructions checked against a per-instruction cycle-trace model.
module tb_core_ctrl;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        mdr_we;
    logic [11:0] alu_op;
    logic        opr2_sel;
    logic        rf_we;
    logic        wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        retire;
    logic        illegal;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    bit          z;
    logic [11:0] aop;
    int          cyc;
    logic [1:0]  psel;
    bit          rfwe;
    bit          wbsel;
  } vec_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;

  logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, opr2_sel, rf_we, wb_sel, pc_we;
  logic        retire, illegal;
  logic [11:0] alu_op;
  logic [1:0]  pc_sel;
  logic        mem_req2, mem_we2, mem_addr_sel2, ir_we2, mdr_we2, opr2_sel2, rf_we2, wb_sel2;
  logic        pc_we2, retire2, illegal2;
  logic [11:0] alu_op2;
  logic [1:0]  pc_sel2;

  outs_t got, got2;
  assign got  = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, alu_op, opr2_sel, rf_we, wb_sel,
                 pc_we, pc_sel, retire, illegal};
  assign got2 = {mem_req2, mem_we2, mem_addr_sel2, ir_we2, mdr_we2, alu_op2, opr2_sel2, rf_we2,
                 wb_sel2, pc_we2, pc_sel2, retire2, illegal2};

  always #5 clk = ~clk;

  core_ctrl #(.XLEN(32), .RESET_STATE_FETCH(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(1'b0), .instr_i(instr), .zero_i(zero),
    .mem_ack_i(mem_ack), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_sel_o(mem_addr_sel), .ir_we_o(ir_we), .mdr_we_o(mdr_we), .alu_op_o(alu_op),
    .opr2_sel_o(opr2_sel), .rf_we_o(rf_we), .wb_sel_o(wb_sel), .pc_we_o(pc_we),
    .pc_sel_o(pc_sel), .retire_o(retire), .illegal_o(illegal)
  );

  core_ctrl #(.XLEN(32), .RESET_STATE_FETCH(1'b0)) u_dut_idle (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_i(instr), .zero_i(zero),
    .mem_ack_i(mem_ack), .mem_req_o(mem_req2), .mem_we_o(mem_we2),
    .mem_addr_sel_o(mem_addr_sel2), .ir_we_o(ir_we2), .mdr_we_o(mdr_we2), .alu_op_o(alu_op2),
    .opr2_sel_o(opr2_sel2), .rf_we_o(rf_we2), .wb_sel_o(wb_sel2), .pc_we_o(pc_we2),
    .pc_sel_o(pc_sel2), .retire_o(retire2), .illegal_o(illegal2)
  );

  int    n_pass = 0;
  int    n_total = 0;
  outs_t exp_q[$];
  bit    ack_q[$];

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, req);
  endtask

  function automatic bit ref_legal(input logic [31:0] ins);
    int f3 = int'(ins[14:12]);
    case (ins[6:0])
      7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17: return 1'b1;
      7'h03:   return f3 inside {0, 1, 2, 4, 5};
      7'h23:   return f3 inside {0, 1, 2};
      7'h63:   return !(f3 inside {2, 3});
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] ref_alu_op(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit sub_sra  = (op == 7'h33) && ins[30];
    bit srai     = (op == 7'h13) && (f3 == 3'd5) && ins[30];
    if (op inside {7'h37, 7'h17, 7'h6F, 7'h67}) f3 = 3'd0;
    return {sub_sra, srai, f3, op};
  endfunction

  task automatic push(input outs_t o, input bit a);
    exp_q.push_back(o);
    ack_q.push_back(a);
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output per cycle for one instruction; ack is random wherever no request is open.
  task automatic build(input logic [31:0] ins, input int fw, input int mw, input bit z);
    logic [6:0] op = ins[6:0];
    outs_t o, base;
    o = '0;
    o.mem_req = 1'b1;
    repeat (fw) push(o, 1'b0);
    o.ir_we = 1'b1;
    push(o, 1'b1);
    base = '0;
    base.alu_op   = ref_alu_op(ins);
    base.opr2_sel = op inside {7'h13, 7'h03, 7'h23, 7'h37, 7'h17};
    if (!ref_legal(ins)) begin
      if (TrapEn) begin
        push(base, rnd_bit());
        o = '0;
        o.illegal = 1'b1;
        repeat (4) push(o, rnd_bit());
      end else begin
        o = base;
        o.pc_we  = 1'b1;
        o.retire = 1'b1;
        push(o, rnd_bit());
      end
      return;
    end
    push(base, rnd_bit());
    o = base;
    if (op == 7'h63) begin
      o.pc_we  = 1'b1;
      o.pc_sel = z ? 2'd1 : 2'd0;
      o.retire = 1'b1;
      push(o, rnd_bit());
      return;
    end
    push(base, rnd_bit());
    if (op == 7'h03 || op == 7'h23) begin
      o.mem_req      = 1'b1;
      o.mem_addr_sel = 1'b1;
      o.mem_we       = (op == 7'h23);
      repeat (mw) push(o, 1'b0);
      if (op == 7'h23) begin
        o.pc_we  = 1'b1;
        o.retire = 1'b1;
        push(o, 1'b1);
        return;
      end
      o.mdr_we = 1'b1;
      push(o, 1'b1);
    end
    o = base;
    o.rf_we  = (ins[11:7] != 5'd0);
    o.wb_sel = (op == 7'h03);
    o.pc_we  = 1'b1;
    o.pc_sel = (op == 7'h6F) ? 2'd1 : ((op == 7'h67) ? 2'd2 : 2'd0);
    o.retire = 1'b1;
    push(o, rnd_bit());
  endtask

  // Plays the queued trace one cycle at a time; entered and left at posedge+1.
  task automatic run_trace(input string nm, input int dec_idx, output int ret_idx,
                           output outs_t dec_o, output outs_t ret_o);
    int    n = 0;
    outs_t e;
    ret_idx = 0;
    dec_o   = '0;
    ret_o   = '0;
    while (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      mem_ack = ack_q.pop_front();
      n++;
      @(negedge clk);
      check_val($sformatf("%s@%0d", nm, n), 32'(got), 32'(e));
      if (n == dec_idx) dec_o = got;
      if (got.retire && ret_idx == 0) begin
        ret_idx = n;
        ret_o   = got;
      end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_val("reset_outs", 32'(got), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t       tbl[11];
    logic [6:0] ops[10];
    logic [31:0] ins;
    int          r_i, fw, mw, sel;
    outs_t       d_o, r_o;

    tbl = '{
      '{32'h002081B3, 0, 0, 1'b0, 12'b000000110011, 4, 2'd0, 1'b1, 1'b0},
      '{32'h402081B3, 0, 0, 1'b0, 12'b100000110011, 4, 2'd0, 1'b1, 1'b0},
      '{32'h4020D193, 1, 0, 1'b0, 12'b011010010011, 5, 2'd0, 1'b1, 1'b0},
      '{32'h0080A283, 0, 3, 1'b0, 12'b000100000011, 8, 2'd0, 1'b1, 1'b1},
      '{32'h0020A223, 0, 0, 1'b0, 12'b000100100011, 4, 2'd0, 1'b0, 1'b0},
      '{32'h00208463, 0, 0, 1'b1, 12'b000001100011, 3, 2'd1, 1'b0, 1'b0},
      '{32'h00208463, 0, 0, 1'b0, 12'b000001100011, 3, 2'd0, 1'b0, 1'b0},
      '{32'h008000EF, 0, 0, 1'b0, 12'b000001101111, 4, 2'd1, 1'b1, 1'b0},
      '{32'h00008067, 0, 0, 1'b0, 12'b000001100111, 4, 2'd2, 1'b0, 1'b0},
      '{32'h123452B7, 0, 0, 1'b0, 12'b000000110111, 4, 2'd0, 1'b1, 1'b0},
      '{32'h00000013, 0, 0, 1'b0, 12'b000000010011, 4, 2'd0, 1'b0, 1'b0}
    };
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};

    // Reset: everything low even with a stray ack.
    mem_ack = 1'b1;
    #2;
    check_val("reset_outs", 32'(got), 32'd0);
    check_val("reset_outs_idle", 32'(got2), 32'd0);
    mem_ack = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // FETCH hold without ack; IDLE instance waits for start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("fetch_hold", 32'(got), 32'(outs_t'({1'b1, 24'd0})));
      check_val("idle_wait", 32'(got2), 32'd0);
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(negedge clk);
    check_val("idle_start_cycle", 32'(got2), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("idle_to_fetch", 32'(mem_req2), 32'd1);

    // Reset during an outstanding fetch drops the request without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_val("async_req_drop", 32'(mem_req), 32'd0);
    check_val("async_req_drop_idle", 32'(mem_req2), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      instr = tbl[i].ins;
      zero  = tbl[i].z;
      build(tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].z);
      run_trace($sformatf("vec%0d", i), tbl[i].fw + 2, r_i, d_o, r_o);
      check_val($sformatf("vec%0d_alu_op", i), 32'(d_o.alu_op), 32'(tbl[i].aop));
      check_val($sformatf("vec%0d_latency", i), 32'(r_i), 32'(tbl[i].cyc));
      check_val($sformatf("vec%0d_pc_sel", i), 32'(r_o.pc_sel), 32'(tbl[i].psel));
      check_val($sformatf("vec%0d_rf_we", i), 32'(r_o.rf_we), 32'(tbl[i].rfwe));
      check_val($sformatf("vec%0d_wb_sel", i), 32'(r_o.wb_sel), 32'(tbl[i].wbsel));
    end

    // Illegal opcode: NOP retiring in DECODE, or a sticky trap.
    instr = 32'h0000000B;
    build(32'h0000000B, 0, 0, 1'b0);
    run_trace("illegal", 2, r_i, d_o, r_o);
    check_val("illegal_retire_cycle", 32'(r_i), TrapEn ? 32'd0 : 32'd2);
    check_val("illegal_flag", 32'(illegal), TrapEn ? 32'd1 : 32'd0);
    do_reset();

    for (int k = 0; k < 60; k++) begin
      do begin
        ins      = $urandom;
        sel      = $urandom_range(0, 9);
        ins[6:0] = ops[sel];
      end while (TrapEn && !ref_legal(ins));
      fw    = $urandom_range(0, 2);
      mw    = $urandom_range(0, 3);
      zero  = rnd_bit();
      instr = ins;
      build(ins, fw, mw, zero);
      run_trace($sformatf("rand%0d_%h", k, ins), fw + 2, r_i, d_o, r_o);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It fetches each instruction over a req/ack memory port and decodes it into the 12-bit ALU operation code {b11, b10, funct3, opcode}. It then sequences execute, memory access, register writeback and the PC update. It sits beside the ALU and datapath registers (PC, IR, MDR, register file) and drives all of their enables and selects.

Parameters:
XLEN, 32, datapath width; used only for the instr width check and documentation.
RESET_STATE_FETCH, 1, when 1 the FSM leaves reset directly in FETCH; when 0 it holds in IDLE until start=1.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE (only used when RESET_STATE_FETCH=0)
instr  in  32  current IR contents, stable from the cycle after ir_we
zero  in  1  ALU condition/zero flag
mem_ack  in  1  memory transfer complete
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  store when 1, with mem_req
mem_addr_sel  out  1  0=PC, 1=alu_out
ir_we  out  1  latch read data into IR
mdr_we  out  1  latch read data into MDR
alu_op  out  12  operation code to ALU
opr2_sel  out  1  0=rs2, 1=immediate
rf_we  out  1  register file write
wb_sel  out  1  0=alu_out, 1=MDR
pc_we  out  1  PC update
pc_sel  out  2  0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
retire  out  1  1-cycle pulse per completed instruction
illegal  out  1  trap flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state goes to FETCH, or IDLE when RESET_STATE_FETCH=0. All outputs are 0, including alu_op=12'h000. Reset asserted during an outstanding mem_req drops the request immediately.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- IDLE: all outputs 0. Move to FETCH when start=1.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ack, ir_we=1 in that same cycle, then go to DECODE. Without ack, stay in FETCH with mem_req held and all other outputs unchanged.
- DECODE: one cycle for register-file read.
- alu_op decode, driven in DECODE..WRITEBACK and 0 in IDLE/FETCH:
  - b11 = instr[30] only for opcode 0110011.
  - b10 = instr[30] only for opcode 0010011 with funct3=101.
  - funct3 field is forced to 000 for LUI, AUIPC, JAL and JALR.
  - alu_op is held constant through WRITEBACK (JAL/JALR rely on alu_out=PC+4).
- opr2_sel=1 for I-type, load, store, LUI and AUIPC; 0 otherwise.
- EXECUTE, by instruction class:
  - R/I-ALU, LUI, AUIPC, JAL, JALR: go to WRITEBACK.
  - Load/store: go to MEM.
  - Branch: pc_we=1, pc_sel = zero ? 1 : 0, retire=1, then go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store. Wait for mem_ack, with the same hold rule as FETCH.
  - Load on ack: mdr_we=1, then go to WRITEBACK.
  - Store on ack: pc_we=1, pc_sel=0, retire=1, then go to FETCH.
- WRITEBACK: rf_we=1 unless rd=instr[11:7]=0. wb_sel=1 only for loads. pc_we=1 with pc_sel = 1 for JAL, 2 for JALR, 0 otherwise. retire=1. Then go to FETCH.
- Latency with mem_ack in the same cycle as req: branch 3, store 4, ALU/jump 4, load 5 cycles.
- mem_ack while mem_req=0 is ignored.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- Legal funct3 restrictions: load funct3 ∈ {000,001,010,100,101}; store funct3 ∈ {000,001,010}; branch funct3 ∉ {010,011}.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to TRAP. TRAP sets illegal=1, drives all other outputs 0, issues no further mem_req and stays there until reset.
- Undefined: an illegal instruction is a NOP. DECODE does pc_we=1, pc_sel=0, retire=1 and goes to FETCH. illegal is tied to 0.

Test Plan:
- add x3,x1,x2 (0x002081B3), ack same cycle: ir_we in cycle 1; alu_op=12'b000000110011 in DECODE..WB; rf_we+pc_we(sel 0)+retire in cycle 4.
- sub (0x402081B3): alu_op=12'b100000110011. srai x3,x1,2 (0x4020D193): alu_op=12'b011010010011, opr2_sel=1.
- lw x5,8(x1) (0x0080A283), mem_ack delayed 3 cycles in MEM: mem_req/mem_addr_sel=1 held 4 cycles; mdr_we on ack; WB has wb_sel=1, rf_we=1.
- beq (0x00208463): zero=1 gives pc_sel=1; zero=0 gives pc_sel=0; both retire in cycle 3, with no rf_we.
- jal x1 (0x008000EF): alu_op=12'b000001101111; WB rf_we=1, pc_sel=1. jalr x0 (0x00008067): rf_we=0, pc_sel=2.
- rst_n low during FETCH wait: mem_req drops asynchronously. Opcode 0x0000000B: TRAP with illegal=1 when macro defined; otherwise retire plus pc+4.
